// File: rtl/mc_result_scaler.sv
// rtl/mc_result_scaler.sv - scales a Monte-Carlo hit count to round(hits*area/iterations)
module mc_result_scaler #(
  parameter int WIDTH      = 4,
  parameter int AREA_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            hits,
  input  logic [WIDTH-1:0]            iterations,
  input  logic [AREA_WIDTH-1:0]       area,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH+AREA_WIDTH-1:0] estimate,
  output logic                        div_by_zero
);

  localparam int PW = WIDTH + AREA_WIDTH;
  localparam int CW = $clog2(PW) + 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] hits_q, hits_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [PW-1:0]    quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    estimate_q, estimate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   rem_shift;

  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    iter_d     = iter_q;
    mcand_d    = mcand_q;
    product_d  = product_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    estimate_d = estimate_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    rem_shift  = {rem_q[WIDTH-1:0], product_q[PW-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          hits_d    = hits;
          iter_d    = iterations;
          mcand_d   = PW'(area);
          product_d = '0;
          rem_d     = '0;
          quot_d    = '0;
          dbz_d     = 1'b0;
          if (iterations == '0) begin
            state_d = DONE;
          end else begin
            state_d = MUL;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end
      MUL: begin
        // hits is consumed LSB first while the multiplicand walks left
        if (hits_q[0]) product_d = product_q + mcand_q;
        hits_d  = hits_q >> 1;
        mcand_d = mcand_q << 1;
        if (cnt_q == '0) begin
          state_d = DIV;
          cnt_d   = CW'(PW - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        product_d = product_q << 1;
        if (rem_shift >= {1'b0, iter_q}) begin
          rem_d  = rem_shift - {1'b0, iter_q};
          quot_d = {quot_q[PW-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift;
          quot_d = {quot_q[PW-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = ROUND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ROUND: begin
        if (({rem_q, 1'b0} >= {2'b00, iter_q}) && (quot_q != '1))
          estimate_d = quot_q + 1'b1;
        else
          estimate_d = quot_q;
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        if (iter_q == '0) begin
          estimate_d = '1;
          dbz_d      = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hits_q     <= '0;
      iter_q     <= '0;
      mcand_q    <= '0;
      product_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      estimate_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hits_q     <= hits_d;
      iter_q     <= iter_d;
      mcand_q    <= mcand_d;
      product_q  <= product_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      estimate_q <= estimate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign estimate    = estimate_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mc_result_scaler.sv
// tb/tb_mc_result_scaler.sv - directed-vector bench for mc_result_scaler
module tb_mc_result_scaler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] hits;
  logic [3:0] iterations;
  logic [3:0] area;
  logic       busy;
  logic       done;
  logic [7:0] estimate;
  logic       div_by_zero;

  int checks;
  int errors;
  logic [7:0] prev_est;

  mc_result_scaler #(.WIDTH(4), .AREA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .hits(hits), .iterations(iterations),
    .area(area), .busy(busy), .done(done), .estimate(estimate), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start at edge k, count edges until done, then verify result and one-cycle pulse
  task automatic run_op(input string tag, input logic [3:0] h, input logic [3:0] i,
                        input logic [3:0] a, input logic [7:0] exp_est,
                        input logic exp_dbz, input int exp_lat);
    int n;
    @(negedge clk);
    hits = h; iterations = i; area = a; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hits = 4'h0; iterations = 4'h0; area = 4'h0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_dbz_clr"}, div_by_zero, 0);
    chk({tag, "_hold"}, estimate, prev_est);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_est"}, estimate, exp_est);
    chk({tag, "_dbz"}, div_by_zero, exp_dbz);
    prev_est = exp_est;
  endtask

  initial begin
    int ndone;
    checks = 0; errors = 0; prev_est = 8'h00;
    rst = 1'b0; start = 1'b0; hits = 4'h0; iterations = 4'h0; area = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_est", estimate, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("t1", 4'd5, 4'd10, 4'd12, 8'd6, 1'b0, 14);
    @(posedge clk);
    #1;
    chk("t1_pulse", done, 0);
    chk("t1_idle", busy, 0);

    run_op("t2", 4'd7, 4'd9, 4'd5, 8'd4, 1'b0, 14);
    run_op("t3a", 4'd1, 4'd2, 4'd1, 8'd1, 1'b0, 14);
    run_op("t3b", 4'd15, 4'd15, 4'd15, 8'd15, 1'b0, 14);
    run_op("t4z", 4'd3, 4'd0, 4'd7, 8'hFF, 1'b1, 1);
    run_op("t4n", 4'd2, 4'd3, 4'd3, 8'd2, 1'b0, 14);

    // Extra starts with different operands while busy must be ignored
    @(negedge clk);
    hits = 4'd5; iterations = 4'd10; area = 4'd12; start = 1'b1;
    @(negedge clk);
    hits = 4'd15; iterations = 4'd1; area = 4'd15; start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 8) ? 1'b1 : 1'b0;
      if (done) ndone++;
    end
    start = 1'b0;
    chk("t5_ndone", ndone, 1);
    chk("t5_est", estimate, 6);
    prev_est = 8'd6;

    // Async reset in the middle of the division
    @(negedge clk);
    hits = 4'd7; iterations = 4'd9; area = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_est", estimate, 0);
    @(negedge clk);
    rst = 1'b1;
    prev_est = 8'h00;
    run_op("t6r", 4'd7, 4'd9, 4'd5, 8'd4, 1'b0, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
